// File: rtl/amp_pkg.sv
// ---------------------------------------------------------------------------
// amp_pkg
//
// Shared constants and types for the preamplifier SPI responder.
//   WIDTH      bits per gain word (channel B in the upper nibble, A in the lower)
//   GAIN_W     width of one channel gain code
//   B_/A_ MSB/LSB  nibble positions of the two channel gains in a word
//   CNT_W      width of the received-bit counter (saturates at CNT_MAX)
//   FULL_CNT   number of received bits that makes a frame complete
//   amp_state_t  responder state machine encoding
//   GAIN_*     named gain codes of the amplifier
// ---------------------------------------------------------------------------
package amp_pkg;

  localparam int WIDTH  = 8;
  localparam int GAIN_W = 4;

  localparam int B_MSB = 7;
  localparam int B_LSB = 4;
  localparam int A_MSB = 3;
  localparam int A_LSB = 0;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = 4'd15;
  localparam logic [CNT_W-1:0] FULL_CNT = 4'd8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } amp_state_t;

  localparam logic [GAIN_W-1:0] GAIN_0    = 4'd0;
  localparam logic [GAIN_W-1:0] GAIN_M1   = 4'd1;
  localparam logic [GAIN_W-1:0] GAIN_M100 = 4'd7;

  // Bit counter increment that sticks at CNT_MAX so very long daisy-chain
  // frames never wrap back into the "short frame" range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/amp_edge_sync.sv
// ---------------------------------------------------------------------------
// amp_edge_sync
//
// Multi-stage synchronizer for one asynchronous pin followed by an edge
// register. The level and the rise/fall flags are registered together, so a
// flag and the synchronized level of any other amp_edge_sync instance refer
// to the same pin sample. Flags appear SYNC_STAGES+1 clocks after the pin edge.
//
// Parameters:
//   SYNC_STAGES  flip-flops in the synchronizer chain (2 or more)
//   RESET_VAL    idle value of the pin, loaded into the whole chain on reset
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   din    asynchronous pin
//   level  synchronized pin level
//   rise   one-cycle pulse on a synchronized low-to-high transition
//   fall   one-cycle pulse on a synchronized high-to-low transition
// ---------------------------------------------------------------------------
module amp_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES:0]   fill;
  logic                   sampled;

  assign sampled = chain[SYNC_STAGES-1];

  // The fill register marks when the chain holds real pin samples instead of
  // reset values. Until then no edge is reported, so a pin that sits away
  // from its idle value across reset release is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      fill  <= '0;
      level <= RESET_VAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
      level <= sampled;
      rise  <= fill[SYNC_STAGES] &  sampled & ~level;
      fall  <= fill[SYNC_STAGES] & ~sampled &  level;
    end
  end

endmodule

// File: rtl/amp_spi_responder.sv
// ---------------------------------------------------------------------------
// amp_spi_responder
//
// SPI slave model of the programmable preamplifier. SCK, CS and MOSI are
// oversampled on the system clock; gain words are shifted in MSB first while
// the previously latched word is shifted out on amp_dout. On CS rising the
// last 8 received bits become the channel B (upper nibble) and channel A
// (lower nibble) gains. Shutdown forces both gains to zero.
//
// Parameters:
//   WIDTH        shift register width (8 for a single amplifier word)
//   SYNC_STAGES  synchronizer depth for every input pin (2 or more)
// Ports:
//   CLK50MHZ     system clock
//   RST          asynchronous active-low reset
//   spi_sck      serial clock from the master, idle low
//   spi_mosi     serial data from the master
//   amp_cs       chip select, active low
//   amp_shdn     shutdown, active high
//   amp_dout     serial data back to the master (shift register MSB)
//   gain_a       latched channel A gain code
//   gain_b       latched channel B gain code
//   gain_update  one-cycle pulse when a complete word is latched
//   frame_err    one-cycle pulse when a frame ends with 1..7 bits
//   busy         high while a frame is in progress
// ---------------------------------------------------------------------------
module amp_spi_responder #(
  parameter int WIDTH       = amp_pkg::WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK50MHZ,
  input  logic                      RST,
  input  logic                      spi_sck,
  input  logic                      spi_mosi,
  input  logic                      amp_cs,
  input  logic                      amp_shdn,
  output logic                      amp_dout,
  output logic [amp_pkg::GAIN_W-1:0] gain_a,
  output logic [amp_pkg::GAIN_W-1:0] gain_b,
  output logic                      gain_update,
  output logic                      frame_err,
  output logic                      busy
);

  import amp_pkg::*;

  logic sck_level_unused;
  logic sck_rise;
  logic sck_fall;
  logic cs_level_unused;
  logic cs_rise;
  logic cs_fall;
  logic mosi_s;
  logic mosi_rise_unused;
  logic mosi_fall_unused;

  logic [SYNC_STAGES-1:0] shdn_chain;
  logic                   shdn_s;

  amp_state_t       state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;

  logic [WIDTH-1:0] sr_next;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] load_word;

  amp_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_sck (
    .clk   (CLK50MHZ),
    .rst_n (RST),
    .din   (spi_sck),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  amp_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_sync_cs (
    .clk   (CLK50MHZ),
    .rst_n (RST),
    .din   (amp_cs),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  amp_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sync_mosi (
    .clk   (CLK50MHZ),
    .rst_n (RST),
    .din   (spi_mosi),
    .level (mosi_s),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  // Shutdown is a level, so a plain synchronizer chain is enough.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      shdn_chain <= '0;
    end else begin
      shdn_chain <= {shdn_chain[SYNC_STAGES-2:0], amp_shdn};
    end
  end

  assign shdn_s    = shdn_chain[SYNC_STAGES-1];
  assign load_word = WIDTH'({gain_b, gain_a});

  // Shift-register and counter values including this cycle's SCK sample.
  // Frame evaluation uses these, so a sample arriving together with the CS
  // rise still counts toward the frame.
  always_comb begin
    sr_next  = shift_reg;
    cnt_next = bit_cnt;
    if (sck_rise) begin
      sr_next  = {shift_reg[WIDTH-2:0], mosi_s};
      cnt_next = sat_inc(bit_cnt);
    end
  end

  // Responder state machine. IDLE waits for CS to fall and preloads the
  // current gains for read-back; SHIFT samples on SCK rise, presents the next
  // MSB on SCK fall, and judges the frame length when CS rises. Shutdown
  // overrides any gain write at the bottom of the block.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      amp_dout    <= 1'b0;
      gain_a      <= GAIN_0;
      gain_b      <= GAIN_0;
      gain_update <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gain_update <= 1'b0;
      frame_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            shift_reg <= load_word;
            bit_cnt   <= '0;
            amp_dout  <= load_word[WIDTH-1];
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          shift_reg <= sr_next;
          bit_cnt   <= cnt_next;
          if (sck_fall) begin
            amp_dout <= shift_reg[WIDTH-1];
          end
          if (cs_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
            if (cnt_next >= FULL_CNT) begin
              if (!shdn_s) begin
                gain_b      <= sr_next[B_MSB:B_LSB];
                gain_a      <= sr_next[A_MSB:A_LSB];
                gain_update <= 1'b1;
              end
            end else if (cnt_next != '0) begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      if (shdn_s) begin
        gain_a <= GAIN_0;
        gain_b <= GAIN_0;
      end
    end
  end

endmodule

// File: tb/tb_amp_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_amp_spi_responder
//
// Directed bench for amp_spi_responder. A word-level model holds the gains
// the amplifier should show; each frame's read-back stream and latch result
// are derived from the frame contents and the model, and a per-cycle monitor
// compares the steady outputs against it. Literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_amp_spi_responder;

  localparam int PHASE = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       spi_sck  = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       amp_cs   = 1'b1;
  logic       amp_shdn = 1'b0;
  logic       amp_dout;
  logic [3:0] gain_a;
  logic [3:0] gain_b;
  logic       gain_update;
  logic       frame_err;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_word = 8'h00;
  bit         model_shdn = 1'b0;
  bit         in_flux    = 1'b1;
  int         gu_cnt     = 0;
  int         fe_cnt     = 0;

  amp_spi_responder dut (
    .CLK50MHZ    (clk),
    .RST         (rst_n),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .amp_cs      (amp_cs),
    .amp_shdn    (amp_shdn),
    .amp_dout    (amp_dout),
    .gain_a      (gain_a),
    .gain_b      (gain_b),
    .gain_update (gain_update),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Between frames the gains must equal the model and no pulse may appear.
  always @(negedge clk) begin
    if (rst_n && !in_flux) begin
      checkOutput("steady_outputs", {gain_b, gain_a, gain_update, frame_err},
                  {model_word, 1'b0, 1'b0});
    end
  end

  // Pulse cycles are counted so each frame can demand exactly one (or none).
  always @(negedge clk) begin
    if (rst_n) begin
      if (gain_update) gu_cnt++;
      if (frame_err)   fe_cnt++;
    end
  end

  // One complete frame of n bits (MSB first) of data. The master reads bit i
  // just before each SCK rise; it must be the old word for the first 8 bits
  // and then the frame's own bits delayed by 8 positions.
  task automatic applyStimulus(input logic [15:0] data, input int n, output logic [15:0] seen);
    logic [7:0] old_word;
    logic       exp_bit;
    bit         exp_gu;
    bit         exp_fe;
    old_word = model_word;
    seen     = '0;
    gu_cnt   = 0;
    fe_cnt   = 0;
    @(posedge clk); #2;
    amp_cs   = 1'b0;
    spi_mosi = data[n-1];
    for (int i = 0; i < n; i++) begin
      repeat (PHASE) @(posedge clk);
      #2;
      if (i == 0) checkOutput("busy_in_frame", {31'd0, busy}, 32'd1);
      exp_bit = (i < 8) ? old_word[7-i] : data[n-1-(i-8)];
      checkOutput("dout_bit", {31'd0, amp_dout}, {31'd0, exp_bit});
      seen = {seen[14:0], amp_dout};
      spi_sck = 1'b1;
      repeat (PHASE) @(posedge clk);
      #2;
      spi_sck = 1'b0;
      if (i + 1 < n) spi_mosi = data[n-2-i];
    end
    repeat (PHASE) @(posedge clk);
    #2;
    in_flux = 1'b1;
    amp_cs  = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    exp_gu = (n >= 8) && !model_shdn;
    exp_fe = (n >= 1) && (n <= 7);
    if (exp_gu) model_word = data[7:0];
    checkOutput("gain_update_pulses", gu_cnt, exp_gu ? 32'd1 : 32'd0);
    checkOutput("frame_err_pulses", fe_cnt, exp_fe ? 32'd1 : 32'd0);
    checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
    in_flux = 1'b0;
  endtask

  initial begin
    logic [15:0] seen;

    #1 rst_n = 1'b0;
    #4;
    checkOutput("reset_outputs", {amp_dout, gain_b, gain_a, gain_update, frame_err, busy}, '0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    in_flux = 1'b0;

    applyStimulus(16'h0091, 8, seen);
    checkOutput("lit_gains_91", {24'd0, gain_b, gain_a}, 32'h91);
    checkOutput("lit_dout_00", {24'd0, seen[7:0]}, 32'h00);

    applyStimulus(16'h0027, 8, seen);
    checkOutput("lit_gains_27", {24'd0, gain_b, gain_a}, 32'h27);
    checkOutput("lit_dout_91", {24'd0, seen[7:0]}, 32'h91);

    applyStimulus(16'h0015, 5, seen);
    checkOutput("lit_short_gains", {24'd0, gain_b, gain_a}, 32'h27);
    checkOutput("lit_short_ferr", fe_cnt, 32'd1);

    applyStimulus(16'h0011, 8, seen);
    checkOutput("lit_gains_11", {24'd0, gain_b, gain_a}, 32'h11);

    applyStimulus(16'hA53C, 16, seen);
    checkOutput("lit_gains_3c", {24'd0, gain_b, gain_a}, 32'h3C);
    checkOutput("lit_dout_daisy", {16'd0, seen}, 32'h11A5);

    in_flux    = 1'b1;
    amp_shdn   = 1'b1;
    model_shdn = 1'b1;
    model_word = 8'h00;
    repeat (6) @(posedge clk);
    #2;
    in_flux = 1'b0;
    applyStimulus(16'h0044, 8, seen);
    checkOutput("lit_shdn_gains", {24'd0, gain_b, gain_a}, 32'h00);
    checkOutput("lit_shdn_no_update", gu_cnt, 32'd0);

    in_flux    = 1'b1;
    amp_shdn   = 1'b0;
    model_shdn = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    in_flux = 1'b0;
    applyStimulus(16'h0044, 8, seen);
    checkOutput("lit_gains_44", {24'd0, gain_b, gain_a}, 32'h44);

    // Reset in the middle of an 8'hFF frame, after four bits.
    gu_cnt = 0;
    fe_cnt = 0;
    @(posedge clk); #2;
    amp_cs   = 1'b0;
    spi_mosi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (PHASE) @(posedge clk);
      #2 spi_sck = 1'b1;
      repeat (PHASE) @(posedge clk);
      #2 spi_sck = 1'b0;
    end
    repeat (2) @(posedge clk);
    #5;
    checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
    in_flux = 1'b1;
    rst_n   = 1'b0;
    #1;
    checkOutput("reset_mid_frame", {amp_dout, gain_b, gain_a, gain_update, frame_err, busy}, '0);
    model_word = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("cs_low_ignored", {31'd0, busy}, 32'd0);
    in_flux = 1'b0;
    for (int i = 0; i < 2; i++) begin
      repeat (PHASE) @(posedge clk);
      #2 spi_sck = 1'b1;
      repeat (PHASE) @(posedge clk);
      #2 spi_sck = 1'b0;
    end
    repeat (PHASE) @(posedge clk);
    #2;
    checkOutput("idle_sck_busy", {31'd0, busy}, 32'd0);
    in_flux = 1'b1;
    amp_cs  = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    checkOutput("idle_no_pulses", gu_cnt + fe_cnt, 32'd0);
    in_flux  = 1'b0;
    spi_mosi = 1'b0;

    applyStimulus(16'h005A, 8, seen);
    checkOutput("lit_gains_5a", {24'd0, gain_b, gain_a}, 32'h5A);
    checkOutput("lit_dout_after_reset", {24'd0, seen[7:0]}, 32'h00);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
